// File: rtl/rv_pkg.sv
// Shared RV32I core definitions: datapath width, ALU op encodings and
// forwarding mux selects.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] FWD_ID  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/forwarding_unit.sv
// Operand forwarding select for the EX stage. EX/MEM has priority over
// MEM/WB, and x0 is never forwarded.
module forwarding_unit
  import rv_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] ex_mem_register_rd,
  input  logic                  ex_mem_regwrite,
  input  logic                  ex_mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_wb_register_rd,
  input  logic                  mem_wb_regwrite,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b
);

  logic mem_live;
  logic wb_live;

  always_comb begin
    mem_live = ex_mem_regwrite && ex_mem_valid && (ex_mem_register_rd != '0);
    wb_live  = mem_wb_regwrite && (mem_wb_register_rd != '0);

    forward_a = FWD_ID;
    if (mem_live && (ex_mem_register_rd == rs1)) begin
      forward_a = FWD_MEM;
    end else if (wb_live && (mem_wb_register_rd == rs1)) begin
      forward_a = FWD_WB;
    end

    forward_b = FWD_ID;
    if (mem_live && (ex_mem_register_rd == rs2)) begin
      forward_b = FWD_MEM;
    end else if (wb_live && (mem_wb_register_rd == rs2)) begin
      forward_b = FWD_WB;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage (forwarding, ALU, branch resolution) and the EX/MEM pipeline
// register. Flush clears control only; stall holds everything.
module ex_mem_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XLEN-1:0]       id_ex_pc,
  input  logic [XLEN-1:0]       id_ex_output_data1,
  input  logic [XLEN-1:0]       id_ex_output_data_2,
  input  logic [XLEN-1:0]       id_ex_sign_extend_immediate,
  input  logic [REG_ADDR_W-1:0] id_ex_register_rs1,
  input  logic [REG_ADDR_W-1:0] id_ex_register_rs2,
  input  logic [REG_ADDR_W-1:0] id_ex_register_rd,
  input  logic                  id_ex_memtoreg,
  input  logic                  id_ex_alusrc,
  input  logic                  id_ex_memread,
  input  logic                  id_ex_memwrite,
  input  logic                  id_ex_branch,
  input  logic                  id_ex_regwrite_control,
  input  logic [3:0]            id_ex_alu_control,
  input  logic [REG_ADDR_W-1:0] mem_wb_register_rd,
  input  logic                  mem_wb_regwrite,
  input  logic [XLEN-1:0]       mem_wb_write_data,
  input  logic                  stall,
  input  logic                  flush,
  output logic [XLEN-1:0]       ex_mem_alu_result,
  output logic [XLEN-1:0]       ex_mem_write_data,
  output logic [REG_ADDR_W-1:0] ex_mem_register_rd,
  output logic                  ex_mem_memtoreg,
  output logic                  ex_mem_memread,
  output logic                  ex_mem_memwrite,
  output logic                  ex_mem_regwrite_control,
  output logic                  ex_mem_branch_taken,
  output logic [XLEN-1:0]       ex_mem_branch_target,
  output logic                  ex_mem_valid
);

  logic [1:0]      forward_a;
  logic [1:0]      forward_b;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] rs2_fwd;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_result_d;
  logic            branch_taken_d;
  logic [XLEN-1:0] branch_target_d;

  logic [XLEN-1:0]       alu_result_q;
  logic [XLEN-1:0]       write_data_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  memtoreg_q;
  logic                  memread_q;
  logic                  memwrite_q;
  logic                  regwrite_q;
  logic                  branch_taken_q;
  logic [XLEN-1:0]       branch_target_q;
  logic                  valid_q;

  forwarding_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_forwarding_unit (
    .rs1                (id_ex_register_rs1),
    .rs2                (id_ex_register_rs2),
    .ex_mem_register_rd (rd_q),
    .ex_mem_regwrite    (regwrite_q),
    .ex_mem_valid       (valid_q),
    .mem_wb_register_rd (mem_wb_register_rd),
    .mem_wb_regwrite    (mem_wb_regwrite),
    .forward_a          (forward_a),
    .forward_b          (forward_b)
  );

  always_comb begin
    unique case (forward_a)
      FWD_MEM: op_a = alu_result_q;
      FWD_WB:  op_a = mem_wb_write_data;
      default: op_a = id_ex_output_data1;
    endcase

    unique case (forward_b)
      FWD_MEM: rs2_fwd = alu_result_q;
      FWD_WB:  rs2_fwd = mem_wb_write_data;
      default: rs2_fwd = id_ex_output_data_2;
    endcase

    op_b = id_ex_alusrc ? id_ex_sign_extend_immediate : rs2_fwd;
  end

  always_comb begin
    case (id_ex_alu_control)
      ALU_AND:  alu_result_d = op_a & op_b;
      ALU_OR:   alu_result_d = op_a | op_b;
      ALU_ADD:  alu_result_d = op_a + op_b;
      ALU_SUB:  alu_result_d = op_a - op_b;
      ALU_XOR:  alu_result_d = op_a ^ op_b;
      ALU_SLL:  alu_result_d = op_a << op_b[4:0];
      ALU_SRL:  alu_result_d = op_a >> op_b[4:0];
      ALU_SRA:  alu_result_d = $unsigned($signed(op_a) >>> op_b[4:0]);
      ALU_SLT:  alu_result_d = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_result_d = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default:  alu_result_d = '0;
    endcase

    // BEQ is decoded as SUB; taken when the difference is zero.
    branch_taken_d  = id_ex_branch && (alu_result_d == '0);
    branch_target_d = id_ex_pc + id_ex_sign_extend_immediate;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result_q    <= '0;
      write_data_q    <= '0;
      rd_q            <= '0;
      memtoreg_q      <= 1'b0;
      memread_q       <= 1'b0;
      memwrite_q      <= 1'b0;
      regwrite_q      <= 1'b0;
      branch_taken_q  <= 1'b0;
      branch_target_q <= '0;
      valid_q         <= 1'b0;
    end else if (flush) begin
      // Bubble: kill side effects, leave data fields as they were.
      memtoreg_q     <= 1'b0;
      memread_q      <= 1'b0;
      memwrite_q     <= 1'b0;
      regwrite_q     <= 1'b0;
      branch_taken_q <= 1'b0;
      valid_q        <= 1'b0;
    end else if (!stall) begin
      alu_result_q    <= alu_result_d;
      write_data_q    <= rs2_fwd;
      rd_q            <= id_ex_register_rd;
      memtoreg_q      <= id_ex_memtoreg;
      memread_q       <= id_ex_memread;
      memwrite_q      <= id_ex_memwrite;
      regwrite_q      <= id_ex_regwrite_control;
      branch_taken_q  <= branch_taken_d;
      branch_target_q <= branch_target_d;
      valid_q         <= 1'b1;
    end
  end

  assign ex_mem_alu_result       = alu_result_q;
  assign ex_mem_write_data       = write_data_q;
  assign ex_mem_register_rd      = rd_q;
  assign ex_mem_memtoreg         = memtoreg_q;
  assign ex_mem_memread          = memread_q;
  assign ex_mem_memwrite         = memwrite_q;
  assign ex_mem_regwrite_control = regwrite_q;
  assign ex_mem_branch_taken     = branch_taken_q;
  assign ex_mem_branch_target    = branch_target_q;
  assign ex_mem_valid            = valid_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage: reset, forwarding priority,
// ALU ops, branch resolution, stall/flush and asynchronous reset.
module tb_ex_mem_stage;

  logic        clk;
  logic        rst;
  logic [31:0] id_ex_pc;
  logic [31:0] id_ex_output_data1;
  logic [31:0] id_ex_output_data_2;
  logic [31:0] id_ex_sign_extend_immediate;
  logic [4:0]  id_ex_register_rs1;
  logic [4:0]  id_ex_register_rs2;
  logic [4:0]  id_ex_register_rd;
  logic        id_ex_memtoreg;
  logic        id_ex_alusrc;
  logic        id_ex_memread;
  logic        id_ex_memwrite;
  logic        id_ex_branch;
  logic        id_ex_regwrite_control;
  logic [3:0]  id_ex_alu_control;
  logic [4:0]  mem_wb_register_rd;
  logic        mem_wb_regwrite;
  logic [31:0] mem_wb_write_data;
  logic        stall;
  logic        flush;
  logic [31:0] ex_mem_alu_result;
  logic [31:0] ex_mem_write_data;
  logic [4:0]  ex_mem_register_rd;
  logic        ex_mem_memtoreg;
  logic        ex_mem_memread;
  logic        ex_mem_memwrite;
  logic        ex_mem_regwrite_control;
  logic        ex_mem_branch_taken;
  logic [31:0] ex_mem_branch_target;
  logic        ex_mem_valid;

  int n_checks;
  int n_fail;

  localparam int NT = 12;
  logic [3:0]  t_op  [NT] = '{4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b1000,
                              4'b0111, 4'b1001, 4'b0111, 4'b0110, 4'b0010, 4'b1111};
  logic [31:0] t_a   [NT] = '{32'hF0F0_1234, 32'hF0F0_0000, 32'hFFFF_0000, 32'h0000_0003,
                              32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'h0000_0001, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0005};
  logic [31:0] t_b   [NT] = '{32'h0FF0_FFFF, 32'h0000_1234, 32'h0F0F_0F0F, 32'h0000_0024,
                              32'h0000_0004, 32'h0000_0004, 32'h0000_0001, 32'h0000_0001,
                              32'hFFFF_FFFF, 32'h0000_0007, 32'h0000_0002, 32'h0000_0007};
  logic [31:0] t_exp [NT] = '{32'h00F0_1234, 32'hF0F0_1234, 32'hF0F0_0F0F, 32'h0000_0030,
                              32'h0800_0000, 32'hF800_0000, 32'h0000_0001, 32'h0000_0000,
                              32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000};

  ex_mem_stage #(
    .XLEN       (32),
    .REG_ADDR_W (5)
  ) dut (
    .clk                         (clk),
    .rst                         (rst),
    .id_ex_pc                    (id_ex_pc),
    .id_ex_output_data1          (id_ex_output_data1),
    .id_ex_output_data_2         (id_ex_output_data_2),
    .id_ex_sign_extend_immediate (id_ex_sign_extend_immediate),
    .id_ex_register_rs1          (id_ex_register_rs1),
    .id_ex_register_rs2          (id_ex_register_rs2),
    .id_ex_register_rd           (id_ex_register_rd),
    .id_ex_memtoreg              (id_ex_memtoreg),
    .id_ex_alusrc                (id_ex_alusrc),
    .id_ex_memread               (id_ex_memread),
    .id_ex_memwrite              (id_ex_memwrite),
    .id_ex_branch                (id_ex_branch),
    .id_ex_regwrite_control      (id_ex_regwrite_control),
    .id_ex_alu_control           (id_ex_alu_control),
    .mem_wb_register_rd          (mem_wb_register_rd),
    .mem_wb_regwrite             (mem_wb_regwrite),
    .mem_wb_write_data           (mem_wb_write_data),
    .stall                       (stall),
    .flush                       (flush),
    .ex_mem_alu_result           (ex_mem_alu_result),
    .ex_mem_write_data           (ex_mem_write_data),
    .ex_mem_register_rd          (ex_mem_register_rd),
    .ex_mem_memtoreg             (ex_mem_memtoreg),
    .ex_mem_memread              (ex_mem_memread),
    .ex_mem_memwrite             (ex_mem_memwrite),
    .ex_mem_regwrite_control     (ex_mem_regwrite_control),
    .ex_mem_branch_taken         (ex_mem_branch_taken),
    .ex_mem_branch_target        (ex_mem_branch_target),
    .ex_mem_valid                (ex_mem_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    id_ex_pc                    = '0;
    id_ex_sign_extend_immediate = '0;
    id_ex_memtoreg              = 1'b0;
    id_ex_alusrc                = 1'b0;
    id_ex_memread               = 1'b0;
    id_ex_memwrite              = 1'b0;
    id_ex_branch                = 1'b0;
    mem_wb_register_rd          = '0;
    mem_wb_regwrite             = 1'b0;
    mem_wb_write_data           = '0;
  endtask

  task automatic set_ex(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic regwrite);
    id_ex_alu_control      = op;
    id_ex_output_data1     = d1;
    id_ex_output_data_2    = d2;
    id_ex_register_rs1     = rs1;
    id_ex_register_rs2     = rs2;
    id_ex_register_rd      = rd;
    id_ex_regwrite_control = regwrite;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    stall    = 1'b0;
    flush    = 1'b0;
    clear_ctrl();
    set_ex(4'b0000, '0, '0, '0, '0, '0, 1'b0);

    // Reset state, including across clock edges
    #2;
    chk("rst_valid", {31'd0, ex_mem_valid}, 32'd0);
    chk("rst_alu", ex_mem_alu_result, 32'd0);
    repeat (2) tick();
    chk("rst_hold_valid", {31'd0, ex_mem_valid}, 32'd0);
    chk("rst_hold_taken", {31'd0, ex_mem_branch_taken}, 32'd0);
    rst = 1'b0;
    tick();
    chk("first_capture_valid", {31'd0, ex_mem_valid}, 32'd1);

    // ADD, no hazard
    set_ex(4'b0010, 32'd5, 32'd7, 5'd1, 5'd2, 5'd5, 1'b1);
    tick();
    chk("add_result", ex_mem_alu_result, 32'd12);
    chk("add_valid", {31'd0, ex_mem_valid}, 32'd1);
    chk("add_rd", {27'd0, ex_mem_register_rd}, 32'd5);
    chk("add_wdata", ex_mem_write_data, 32'd7);

    // Double hazard: EX/MEM x3=100 must beat MEM/WB x3=50
    set_ex(4'b0010, 32'd100, 32'd0, 5'd1, 5'd2, 5'd3, 1'b1);
    tick();
    chk("setup_x3", ex_mem_alu_result, 32'd100);
    set_ex(4'b0010, 32'd1, 32'd0, 5'd3, 5'd0, 5'd6, 1'b1);
    mem_wb_register_rd = 5'd3;
    mem_wb_regwrite    = 1'b1;
    mem_wb_write_data  = 32'd50;
    tick();
    chk("fwd_mem_wins", ex_mem_alu_result, 32'd100);

    // MEM/WB only (EX/MEM now holds rd=x6)
    set_ex(4'b0010, 32'd1, 32'd0, 5'd3, 5'd0, 5'd7, 1'b1);
    tick();
    chk("fwd_wb", ex_mem_alu_result, 32'd50);

    // x0 is never forwarded from either stage
    set_ex(4'b0010, 32'd100, 32'd0, 5'd1, 5'd2, 5'd0, 1'b1);
    mem_wb_register_rd = 5'd0;
    tick();
    chk("setup_x0", ex_mem_alu_result, 32'd100);
    set_ex(4'b0010, 32'd1, 32'd0, 5'd0, 5'd0, 5'd8, 1'b1);
    tick();
    chk("fwd_x0", ex_mem_alu_result, 32'd1);

    // Store: rs2=x8 forwarded from EX/MEM, address from immediate
    clear_ctrl();
    set_ex(4'b0010, 32'h40, 32'hDEAD, 5'd9, 5'd8, 5'd0, 1'b0);
    id_ex_alusrc                = 1'b1;
    id_ex_memwrite              = 1'b1;
    id_ex_sign_extend_immediate = 32'd4;
    tick();
    chk("store_addr", ex_mem_alu_result, 32'h44);
    chk("store_wdata_fwd", ex_mem_write_data, 32'd1);
    chk("store_memwrite", {31'd0, ex_mem_memwrite}, 32'd1);

    // BEQ taken / not taken with backward offset
    clear_ctrl();
    set_ex(4'b0110, 32'd9, 32'd9, 5'd1, 5'd2, 5'd0, 1'b0);
    id_ex_branch                = 1'b1;
    id_ex_pc                    = 32'h100;
    id_ex_sign_extend_immediate = 32'hFFFF_FFF8;
    tick();
    chk("beq_taken", {31'd0, ex_mem_branch_taken}, 32'd1);
    chk("beq_target", ex_mem_branch_target, 32'h0F8);
    id_ex_output_data_2 = 32'd8;
    tick();
    chk("beq_not_taken", {31'd0, ex_mem_branch_taken}, 32'd0);
    chk("beq_nt_result", ex_mem_alu_result, 32'd1);

    // Load a fully-populated entry, then stall for 3 cycles
    set_ex(4'b0110, 32'd9, 32'd9, 5'd1, 5'd2, 5'd9, 1'b1);
    id_ex_memtoreg              = 1'b1;
    id_ex_memread               = 1'b1;
    id_ex_memwrite              = 1'b1;
    id_ex_pc                    = 32'h200;
    id_ex_sign_extend_immediate = 32'h10;
    tick();
    chk("pre_stall_taken", {31'd0, ex_mem_branch_taken}, 32'd1);
    clear_ctrl();
    set_ex(4'b0010, 32'd5, 32'd7, 5'd1, 5'd2, 5'd4, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_alu", ex_mem_alu_result, 32'd0);
      chk("stall_rd", {27'd0, ex_mem_register_rd}, 32'd9);
      chk("stall_ctrl", {28'd0, ex_mem_valid, ex_mem_regwrite_control, ex_mem_memwrite,
                         ex_mem_branch_taken}, 32'hF);
      chk("stall_target", ex_mem_branch_target, 32'h210);
    end

    // Stall and flush together: flush wins, data fields are kept
    flush = 1'b1;
    tick();
    chk("flush_ctrl", {26'd0, ex_mem_valid, ex_mem_regwrite_control, ex_mem_memwrite,
                       ex_mem_branch_taken, ex_mem_memread, ex_mem_memtoreg}, 32'd0);
    chk("flush_rd_kept", {27'd0, ex_mem_register_rd}, 32'd9);
    chk("flush_target_kept", ex_mem_branch_target, 32'h210);
    stall = 1'b0;
    flush = 1'b0;

    // ALU op table
    for (int i = 0; i < NT; i++) begin
      set_ex(t_op[i], t_a[i], t_b[i], 5'd1, 5'd2, 5'd5, 1'b0);
      tick();
      chk($sformatf("alu_op_%b", t_op[i]), ex_mem_alu_result, t_exp[i]);
    end

    // SRA via immediate operand
    set_ex(4'b1000, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 5'd2, 5'd5, 1'b0);
    id_ex_alusrc                = 1'b1;
    id_ex_sign_extend_immediate = 32'd4;
    tick();
    chk("sra_imm", ex_mem_alu_result, 32'hF800_0000);
    clear_ctrl();

    // Asynchronous reset between edges
    set_ex(4'b0010, 32'd5, 32'd7, 5'd1, 5'd2, 5'd5, 1'b1);
    tick();
    chk("pre_rst_alu", ex_mem_alu_result, 32'd12);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_alu", ex_mem_alu_result, 32'd0);
    chk("async_rst_ctrl", {27'd0, ex_mem_valid, ex_mem_regwrite_control,
                           ex_mem_register_rd[2:0]}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_release_no_edge", {31'd0, ex_mem_valid}, 32'd0);
    tick();
    chk("post_rst_alu", ex_mem_alu_result, 32'd12);
    chk("post_rst_valid", {31'd0, ex_mem_valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
